// File: rtl/cpu24_multicycle_cu.sv
// Multi-cycle control unit for the 24-bit CPU.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the
// DataPath control lines. It also handles the memory-ready handshake, the memory timeout
// fault, HALT, illegal opcodes, and a retired-instruction counter.
//
// Ports:
//   Clock, Reset_n     : clock (rising edge) and asynchronous active-low reset
//   Opcode             : opcode field from the instruction register
//   MemReady           : memory completes the current access this cycle
//   PCWrite, IRWrite   : PC / IR load enables (gated by MemReady in FETCH)
//   IorD               : memory address select (0 = PC, 1 = ALU result)
//   RegDst .. ALUSrc   : DataPath controls, same meaning as in the single-cycle CU
//   ALUOp              : 00 add, 01 subtract, 10 decode from funct
//   StateOut           : current state encoding (debug)
//   IllegalOp          : one-cycle pulse in the FETCH cycle after an undefined opcode
//   Halted, BusFault   : core stopped by HALT / by a memory timeout
//   InstrCount         : saturating count of retired instructions
module cpu24_multicycle_cu #(
   parameter int unsigned          OPCODE_W    = 4,
   parameter logic [OPCODE_W-1:0]  OP_RTYPE    = 'd0,
   parameter logic [OPCODE_W-1:0]  OP_ADDI     = 'd4,
   parameter logic [OPCODE_W-1:0]  OP_LW       = 'd8,
   parameter logic [OPCODE_W-1:0]  OP_SW       = 'd9,
   parameter logic [OPCODE_W-1:0]  OP_BEQ      = 'd10,
   parameter logic [OPCODE_W-1:0]  OP_HALT     = 'd15,
   parameter int unsigned          MEM_TIMEOUT = 16,
   parameter int unsigned          CNT_W       = 24
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic [OPCODE_W-1:0] Opcode,
   input  logic                MemReady,
   output logic                PCWrite,
   output logic                IRWrite,
   output logic                IorD,
   output logic                RegDst,
   output logic                Branch,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                RegWrite,
   output logic                MemToReg,
   output logic                ALUSrc,
   output logic [1:0]          ALUOp,
   output logic [3:0]          StateOut,
   output logic                IllegalOp,
   output logic                Halted,
   output logic                BusFault,
   output logic [CNT_W-1:0]    InstrCount
);

   // Wait counter only needs to hold 0 .. MEM_TIMEOUT-1.
   localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StExecR  = 4'd2,
      StWbR    = 4'd3,
      StExecI  = 4'd4,
      StWbI    = 4'd5,
      StAddr   = 4'd6,
      StMemRd  = 4'd7,
      StWbMem  = 4'd8,
      StMemWr  = 4'd9,
      StBranch = 4'd10,
      StHalt   = 4'd11,
      StFault  = 4'd12
   } state_e;

   state_e            state_q, state_d;
   logic [TO_W-1:0]   timeout_q, timeout_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              illegal_q, illegal_d;
   logic              retire;
   logic              mem_wait;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= StFetch;
         timeout_q <= '0;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
         illegal_q <= illegal_d;
      end
   end

   // Next state, retire and timeout bookkeeping.
   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
      retire    = 1'b0;
      mem_wait  = 1'b0;

      unique case (state_q)
         StFetch: begin
            mem_wait = !MemReady;
            if (MemReady) state_d = StDecode;
         end
         StDecode: begin
            if (Opcode == OP_RTYPE) begin
               state_d = StExecR;
            end else if (Opcode == OP_ADDI) begin
               state_d = StExecI;
            end else if (Opcode == OP_LW || Opcode == OP_SW) begin
               state_d = StAddr;
            end else if (Opcode == OP_BEQ) begin
               state_d = StBranch;
            end else if (Opcode == OP_HALT) begin
               state_d = StHalt;
               retire  = 1'b1;   // HALT retires on entry
            end else begin
               state_d   = StFetch;
               illegal_d = 1'b1;
            end
         end
         StExecR:  state_d = StWbR;
         StWbR: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StExecI:  state_d = StWbI;
         StWbI: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StAddr:   state_d = (Opcode == OP_SW) ? StMemWr : StMemRd;
         StMemRd: begin
            mem_wait = !MemReady;
            if (MemReady) state_d = StWbMem;
         end
         StWbMem: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StMemWr: begin
            mem_wait = !MemReady;
            if (MemReady) begin
               state_d = StFetch;
               retire  = 1'b1;
            end
         end
         StBranch: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StHalt:   state_d = StHalt;
         StFault:  state_d = StFault;
         default:  state_d = StFetch;
      endcase

      // The MEM_TIMEOUT-th consecutive not-ready cycle faults on its closing edge; a
      // MemReady=1 in that cycle is not a wait cycle, so the access completes instead.
      if (MEM_TIMEOUT != 0 && mem_wait && timeout_q == TO_LAST) begin
         state_d = StFault;
      end

      if (MEM_TIMEOUT == 0 || !mem_wait || state_d != state_q) begin
         timeout_d = '0;
      end else begin
         timeout_d = timeout_q + TO_W'(1);
      end

      if (retire && count_q != {CNT_W{1'b1}}) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Moore control outputs; the FETCH load enables are the only MemReady-dependent terms.
   always_comb begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      IorD     = 1'b0;
      RegDst   = 1'b0;
      Branch   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      MemToReg = 1'b0;
      ALUSrc   = 1'b0;
      ALUOp    = 2'b00;

      unique case (state_q)
         StFetch: begin
            MemRead = 1'b1;
            PCWrite = MemReady;
            IRWrite = MemReady;
         end
         StExecR: ALUOp = 2'b10;
         StWbR: begin
            ALUOp    = 2'b10;
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         StExecI:  ALUSrc = 1'b1;
         StWbI: begin
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
         end
         StAddr:   ALUSrc = 1'b1;
         StMemRd: begin
            ALUSrc  = 1'b1;
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         StWbMem: begin
            MemToReg = 1'b1;
            RegWrite = 1'b1;
         end
         StMemWr: begin
            ALUSrc   = 1'b1;
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         StBranch: begin
            Branch = 1'b1;   // DataPath qualifies with its Zero flag
            ALUOp  = 2'b01;
         end
         default: ;
      endcase
   end

   assign StateOut   = state_q;
   assign IllegalOp  = illegal_q;
   assign Halted     = (state_q == StHalt);
   assign BusFault   = (state_q == StFault);
   assign InstrCount = count_q;

endmodule

// File: tb/tb_cpu24_multicycle_cu.sv
// Bench for cpu24_multicycle_cu: stimulus builds each instruction as a list of cycles,
// pushes the expected per-cycle outputs into a queue, and a negedge monitor compares.
module tb_cpu24_multicycle_cu;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned TMO   = 4;

   localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_WB_R = 3, S_EXEC_I = 4;
   localparam int S_WB_I = 5, S_ADDR = 6, S_MEM_RD = 7, S_WB_MEM = 8, S_MEM_WR = 9;
   localparam int S_BRANCH = 10, S_HALT = 11, S_FAULT = 12;

   localparam logic [3:0] OP_RTYPE = 4'd0, OP_ADDI = 4'd4, OP_LW = 4'd8, OP_SW = 4'd9;
   localparam logic [3:0] OP_BEQ = 4'd10, OP_HALT = 4'd15;

   logic             Clock = 1'b0;
   logic             Reset_n = 1'b0;
   logic [3:0]       Opcode = 4'd0;
   logic             MemReady = 1'b0;
   logic             PCWrite, IRWrite, IorD, RegDst, Branch, MemRead, MemWrite;
   logic             RegWrite, MemToReg, ALUSrc;
   logic [1:0]       ALUOp;
   logic [3:0]       StateOut;
   logic             IllegalOp, Halted, BusFault;
   logic [CNT_W-1:0] InstrCount;

   cpu24_multicycle_cu #(
      .OPCODE_W    (4),
      .MEM_TIMEOUT (TMO),
      .CNT_W       (CNT_W)
   ) dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .Opcode     (Opcode),
      .MemReady   (MemReady),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .IorD       (IorD),
      .RegDst     (RegDst),
      .Branch     (Branch),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .MemToReg   (MemToReg),
      .ALUSrc     (ALUSrc),
      .ALUOp      (ALUOp),
      .StateOut   (StateOut),
      .IllegalOp  (IllegalOp),
      .Halted     (Halted),
      .BusFault   (BusFault),
      .InstrCount (InstrCount)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic pcw, irw, iord, regdst, branch, memrd, memwr, regwr, memtoreg, alusrc;
      logic [1:0] aluop;
      logic [3:0] st;
      logic ill, halted, fault;
      logic [CNT_W-1:0] cnt;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_n = 0;
   int   m_cnt = 0;      // model of retired instructions
   bit   ill_pend = 1'b0;
   int   ill_ops[10] = '{1, 2, 3, 5, 6, 7, 11, 12, 13, 14};

   // Control values the specification lists for each state.
   function automatic obs_t expect_for(int st, logic mr);
      obs_t e;
      e = '0;
      e.st = 4'(st);
      case (st)
         S_FETCH:  begin e.memrd = 1'b1; e.pcw = mr; e.irw = mr; end
         S_EXEC_R: e.aluop = 2'b10;
         S_WB_R:   begin e.aluop = 2'b10; e.regdst = 1'b1; e.regwr = 1'b1; end
         S_EXEC_I: e.alusrc = 1'b1;
         S_WB_I:   begin e.alusrc = 1'b1; e.regwr = 1'b1; end
         S_ADDR:   e.alusrc = 1'b1;
         S_MEM_RD: begin e.alusrc = 1'b1; e.memrd = 1'b1; e.iord = 1'b1; end
         S_WB_MEM: begin e.memtoreg = 1'b1; e.regwr = 1'b1; end
         S_MEM_WR: begin e.alusrc = 1'b1; e.memwr = 1'b1; e.iord = 1'b1; end
         S_BRANCH: begin e.branch = 1'b1; e.aluop = 2'b01; end
         S_HALT:   e.halted = 1'b1;
         S_FAULT:  e.fault = 1'b1;
         default:  ;
      endcase
      e.cnt = CNT_W'(m_cnt);
      e.ill = ill_pend;
      return e;
   endfunction

   function automatic void bump();
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
   endfunction

   function automatic logic rr(bit rdy);
      return rdy ? 1'b1 : 1'($urandom);
   endfunction

   task automatic chk(string name, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   // Monitor: every active cycle the stimulus queued exactly one expectation.
   always @(negedge Clock) begin
      obs_t e, g;
      cyc_n++;
      if (Reset_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g.pcw = PCWrite;   g.irw = IRWrite;    g.iord = IorD;       g.regdst = RegDst;
         g.branch = Branch; g.memrd = MemRead;  g.memwr = MemWrite;  g.regwr = RegWrite;
         g.memtoreg = MemToReg; g.alusrc = ALUSrc; g.aluop = ALUOp;  g.st = StateOut;
         g.ill = IllegalOp; g.halted = Halted;  g.fault = BusFault;  g.cnt = InstrCount;
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL cycle%0d outputs: state got %0d exp %0d, vector got %h exp %h",
                     cyc_n, g.st, e.st, g, e);
         end
      end
   end

   // One clock cycle: drive inputs, queue the expectation, advance to just past the edge.
   task automatic cyc(int st, logic mr, logic [3:0] op);
      MemReady = mr;
      Opcode   = op;
      exp_q.push_back(expect_for(st, mr));
      ill_pend = 1'b0;
      @(posedge Clock);
      #1;
   endtask

   // Whole instruction: fw / mw not-ready cycles in FETCH / the memory state.
   task automatic instr(logic [3:0] op, int fw, int mw, bit rdy);
      for (int i = 0; i < fw; i++) cyc(S_FETCH, 1'b0, 4'($urandom));
      cyc(S_FETCH, 1'b1, 4'($urandom));
      cyc(S_DECODE, rr(rdy), op);
      case (op)
         OP_RTYPE: begin cyc(S_EXEC_R, rr(rdy), op); cyc(S_WB_R, rr(rdy), op); bump(); end
         OP_ADDI:  begin cyc(S_EXEC_I, rr(rdy), op); cyc(S_WB_I, rr(rdy), op); bump(); end
         OP_LW: begin
            cyc(S_ADDR, rr(rdy), op);
            for (int i = 0; i < mw; i++) cyc(S_MEM_RD, 1'b0, op);
            cyc(S_MEM_RD, 1'b1, op);
            cyc(S_WB_MEM, rr(rdy), op);
            bump();
         end
         OP_SW: begin
            cyc(S_ADDR, rr(rdy), op);
            for (int i = 0; i < mw; i++) cyc(S_MEM_WR, 1'b0, op);
            cyc(S_MEM_WR, 1'b1, op);
            bump();
         end
         OP_BEQ:   begin cyc(S_BRANCH, rr(rdy), op); bump(); end
         OP_HALT:  bump();
         default:  ill_pend = 1'b1;
      endcase
   endtask

   task automatic do_reset();
      Reset_n  = 1'b0;
      MemReady = 1'b0;
      #1;
      chk("reset_state", int'(StateOut), S_FETCH);
      chk("reset_count", int'(InstrCount), 0);
      chk("reset_flags", int'({IllegalOp, Halted, BusFault}), 0);
      m_cnt    = 0;
      ill_pend = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      Reset_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] op;
      int k;
      do_reset();

      // Directed program with memory always ready: 4+4+5+4+3 = 20 cycles, count 5.
      instr(OP_RTYPE, 0, 0, 1'b1);
      instr(OP_ADDI,  0, 0, 1'b1);
      instr(OP_LW,    0, 0, 1'b1);
      instr(OP_SW,    0, 0, 1'b1);
      instr(OP_BEQ,   0, 0, 1'b1);
      chk("count_after_program", int'(InstrCount), 5);

      // Load stalled three cycles in MEM_RD; no fault below the timeout.
      instr(OP_LW, 0, 3, 1'b1);
      // Undefined opcode: pulse, no count.
      instr(4'd3, 0, 0, 1'b1);
      cyc(S_FETCH, 1'b1, 4'd0);
      cyc(S_DECODE, 1'b1, OP_BEQ);
      cyc(S_BRANCH, 1'b1, OP_BEQ);
      bump();

      // Random program; the narrow counter saturates along the way.
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 5);
         case (k)
            0: op = OP_RTYPE;
            1: op = OP_ADDI;
            2: op = OP_LW;
            3: op = OP_SW;
            4: op = OP_BEQ;
            default: op = 4'(ill_ops[$urandom_range(0, 9)]);
         endcase
         instr(op, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), 1'b0);
      end
      chk("count_saturated", int'(InstrCount), (1 << CNT_W) - 1);

      // Asynchronous reset in the middle of WB_R with MemReady=1.
      cyc(S_FETCH, 1'b1, 4'd0);
      cyc(S_DECODE, 1'b1, OP_RTYPE);
      cyc(S_EXEC_R, 1'b1, OP_RTYPE);
      MemReady = 1'b1;
      Opcode   = OP_RTYPE;
      exp_q.push_back(expect_for(S_WB_R, 1'b1));
      @(negedge Clock);
      #1;
      Reset_n = 1'b0;
      #1;
      chk("async_rst_state", int'(StateOut), S_FETCH);
      chk("async_rst_count", int'(InstrCount), 0);
      chk("async_rst_pcwrite", int'({MemRead, IRWrite, PCWrite}), 7);
      m_cnt    = 0;
      ill_pend = 1'b0;
      @(posedge Clock);
      #1;
      Reset_n = 1'b1;

      // HALT after one instruction: counted on entry, then absorbing.
      instr(OP_BEQ, 0, 0, 1'b1);
      instr(OP_HALT, 1, 0, 1'b0);
      for (int i = 0; i < 100; i++) cyc(S_HALT, 1'($urandom), 4'($urandom));
      chk("halt_count", int'(InstrCount), 2);
      do_reset();

      // Memory stuck not-ready in FETCH: fault after TMO cycles, absorbing.
      for (int i = 0; i < int'(TMO); i++) cyc(S_FETCH, 1'b0, 4'($urandom));
      for (int i = 0; i < 10; i++) cyc(S_FAULT, 1'($urandom), 4'($urandom));
      chk("fault_flag", int'(BusFault), 1);
      do_reset();

      // Normal operation resumes after reset.
      instr(OP_SW, 2, 3, 1'b0);
      @(posedge Clock);
      #1;
      chk("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu24_multicycle_cu.md
Name: cpu24_multicycle_cu

Overview:
- Parametrised multi-cycle control unit for the 24-bit CPU; successor to the single-cycle combinational CU.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives the existing DataPath control lines.
- Adds a memory-ready handshake with a timeout fault, HALT and illegal-opcode handling, and a retired-instruction counter.

Parameters:
- OPCODE_W, 4, opcode field width.
- OP_RTYPE, 0, R-type opcode value.
- OP_ADDI, 4, add-immediate opcode value.
- OP_LW, 8, load opcode value.
- OP_SW, 9, store opcode value.
- OP_BEQ, 10, branch-equal opcode value.
- OP_HALT, 15, halt opcode value.
- MEM_TIMEOUT, 16, number of consecutive MemReady=0 cycles in one memory state before fault; 0 disables the timeout.
- CNT_W, 24, width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Opcode  in  OPCODE_W  opcode field from the DataPath instruction register.
- MemReady  in  1  memory completes the current access in this cycle.
- PCWrite  out  1  PC update enable.
- IRWrite  out  1  instruction register load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc  out  1 each  same meaning as the single-cycle CU.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = decode from funct field.
- StateOut  out  4  current state encoding, for debug.
- IllegalOp  out  1  one-cycle pulse on an undefined opcode.
- Halted  out  1  core is stopped by HALT.
- BusFault  out  1  core is stopped by memory timeout.
- InstrCount  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State goes to FETCH (0).
  - InstrCount, timeout counter, IllegalOp, Halted and BusFault go to 0.
  - Outputs take their FETCH values with MemReady gating.
  - Reset mid-instruction abandons the instruction with no count.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, EXEC_I=4, WB_I=5, ADDR=6, MEM_RD=7, WB_MEM=8, MEM_WR=9, BRANCH=10, HALT=11, FAULT=12.
- Control outputs (Moore by state; any control not listed is 0):
  - FETCH: MemRead=1, IorD=0; PCWrite=IRWrite=MemReady (the only Mealy term).
  - DECODE: all controls 0.
  - EXEC_R: ALUOp=10.
  - WB_R: ALUOp=10, RegDst=1, RegWrite=1.
  - EXEC_I: ALUSrc=1, ALUOp=00.
  - WB_I: ALUSrc=1, RegWrite=1.
  - ADDR: ALUSrc=1, ALUOp=00.
  - MEM_RD: ALUSrc=1, MemRead=1, IorD=1.
  - WB_MEM: MemToReg=1, RegWrite=1.
  - MEM_WR: ALUSrc=1, MemWrite=1, IorD=1.
  - BRANCH: Branch=1, ALUOp=01. The DataPath ANDs Branch with its Zero flag.
  - HALT, FAULT: all controls 0.
- Transitions:
  - FETCH stays until MemReady=1, then goes to DECODE.
  - DECODE dispatches by Opcode:
    - RTYPE to EXEC_R; ADDI to EXEC_I; LW or SW to ADDR; BEQ to BRANCH; HALT to HALT.
    - Any other value goes to FETCH with IllegalOp=1 for exactly that cycle; it is not counted.
  - EXEC_R to WB_R to FETCH. EXEC_I to WB_I to FETCH.
  - ADDR goes to MEM_RD for LW or MEM_WR for SW; Opcode is stable from the IR.
  - MEM_RD stays until MemReady=1, then goes to WB_MEM, then FETCH.
  - MEM_WR stays until MemReady=1, then goes to FETCH.
  - BRANCH goes to FETCH.
  - HALT and FAULT are absorbing until reset.
- Latency with MemReady tied to 1: BEQ takes 3 cycles; R-type, ADDI and SW take 4; LW takes 5.
- Retire counting:
  - InstrCount increments by 1 on transitions into FETCH from WB_R, WB_I, WB_MEM, MEM_WR or BRANCH.
  - HALT is counted on entry to HALT.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
- Memory timeout:
  - The timeout counter clears on every state change and whenever MemReady=1.
  - It increments each cycle in FETCH, MEM_RD or MEM_WR while MemReady=0.
  - Reaching MEM_TIMEOUT moves the block to FAULT on the next edge.
  - A MemReady=1 arriving in the same cycle the count reaches MEM_TIMEOUT wins: the access completes and no fault is raised.
- Halted=1 exactly while in HALT; BusFault=1 exactly while in FAULT.

Test Plan:
- Reset handling: reset asserted mid-WB_R, MemReady=1 → StateOut=0 and InstrCount=0 asynchronously. After release: MemRead=1, IRWrite=1 and PCWrite=1 in the first cycle.
- Full sequence, MemReady=1: opcodes R, ADDI, LW, SW, BEQ →
  - each instruction takes 4, 4, 5, 4 and 3 cycles respectively;
  - per-state control values match the list above;
  - InstrCount=5 after 20 cycles.
- LW with MemReady held 0 for 3 cycles in MEM_RD → MemRead=1 and IorD=1 held for 4 cycles, then WB_MEM with MemToReg=1 and RegWrite=1. No fault.
- MEM_TIMEOUT=4 with MemReady stuck at 0 in FETCH → FAULT after 4 cycles. BusFault=1 and all controls 0 until reset.
- Opcode=3 in DECODE → IllegalOp pulses 1 cycle, return to FETCH, InstrCount unchanged.
- Opcode=15 → HALT, Halted=1, InstrCount +1. State is unchanged for 100 cycles.
